// File: rtl/riscv_pkg.sv
// Shared RV64IM decode definitions: opcodes, immediate classes and the
// decoded-entry record carried through the decode skid buffer.
package riscv_pkg;

  localparam int XLEN      = 64;
  localparam int CS_ADDR_W = 12;

  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_OP        = 7'b0110011;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_OP_32     = 7'b0111011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_SH,
    IMM_NONE
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [CS_ADDR_W-1:0] cs_addr;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic [XLEN-1:0]      imm;
    logic                 illegal;
  } de_entry_t;

  // Immediate-shift forms reuse instr[25] as shamt[5], so it must not leak into cs_addr.
  function automatic logic is_shift_imm(input logic [6:0] opcode, input logic [2:0] funct3);
    return ((opcode == OP_OP_IMM) || (opcode == OP_OP_IMM_32)) &&
           ((funct3 == 3'b001) || (funct3 == 3'b101));
  endfunction

  function automatic imm_type_e imm_type(input logic [6:0] opcode, input logic [2:0] funct3);
    imm_type_e t;
    case (opcode)
      OP_LOAD, OP_JALR:          t = IMM_I;
      OP_OP_IMM, OP_OP_IMM_32:   t = is_shift_imm(opcode, funct3) ? IMM_SH : IMM_I;
      OP_STORE:                  t = IMM_S;
      OP_BRANCH:                 t = IMM_B;
      OP_LUI, OP_AUIPC:          t = IMM_U;
      OP_JAL:                    t = IMM_J;
      default:                   t = IMM_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and control-store-side handshake bundle of the decode stage.
interface decode_stage_if;
  import riscv_pkg::*;

  logic                 if_valid;
  logic                 if_ready;
  logic [31:0]          if_instr;
  logic [XLEN-1:0]      if_pc;
  logic                 de_valid;
  logic                 de_ready;
  logic [XLEN-1:0]      de_pc;
  logic [CS_ADDR_W-1:0] de_cs_addr;
  logic [4:0]           de_rs1;
  logic [4:0]           de_rs2;
  logic [4:0]           de_rd;
  logic [XLEN-1:0]      de_imm;
  logic                 de_illegal;

  modport master (
    output if_valid, if_instr, if_pc, de_ready,
    input  if_ready, de_valid, de_pc, de_cs_addr, de_rs1, de_rs2, de_rd, de_imm, de_illegal
  );

  modport slave (
    input  if_valid, if_instr, if_pc, de_ready,
    output if_ready, de_valid, de_pc, de_cs_addr, de_rs1, de_rs2, de_rd, de_imm, de_illegal
  );

endinterface

// File: rtl/imm_gen.sv
// Combinational RV64 immediate generator: selects the I/S/B/U/J/shamt form
// from the opcode and sign-extends it to XLEN.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm
);

  imm_type_e w_type;

  assign w_type = imm_type(i_instr[6:0], i_instr[14:12]);

  always_comb begin
    o_imm = '0;
    case (w_type)
      IMM_I:  o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
      IMM_S:  o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:  o_imm = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                       i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U:  o_imm = {{(XLEN-32){i_instr[31]}}, i_instr[31:12], 12'b0};
      IMM_J:  o_imm = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                       i_instr[20], i_instr[30:21], 1'b0};
      // 32-bit shifts only have a 5-bit shamt; bit 25 belongs to funct7 there.
      IMM_SH: o_imm = (i_instr[6:0] == OP_OP_IMM) ? {{(XLEN-6){1'b0}}, i_instr[25:20]}
                                                  : {{(XLEN-5){1'b0}}, i_instr[24:20]};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes fetched instructions on entry and holds them in a
// two-slot (main + skid) registered buffer toward the control store.
module decode_stage
  import riscv_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  decode_stage_if.slave bus
);

  logic [XLEN-1:0] w_imm;
  de_entry_t       w_new;
  de_entry_t       r_main;
  de_entry_t       r_skid;
  logic            r_main_valid;
  logic            r_skid_valid;
  logic            w_accept;
  logic            w_drain;

  imm_gen u_imm_gen (
    .i_instr (bus.if_instr),
    .o_imm   (w_imm)
  );

  function automatic logic [CS_ADDR_W-1:0] cs_addr(input logic [31:0] instr);
    logic [CS_ADDR_W-1:0] a;
    a = {instr[6:0], instr[14:12], instr[30], instr[25]};
    if (is_shift_imm(instr[6:0], instr[14:12])) a[0] = 1'b0;
    return a;
  endfunction

  always_comb begin
    w_new         = '0;
    w_new.pc      = bus.if_pc;
    w_new.cs_addr = cs_addr(bus.if_instr);
    w_new.rs1     = bus.if_instr[19:15];
    w_new.rs2     = bus.if_instr[24:20];
    w_new.rd      = bus.if_instr[11:7];
    w_new.imm     = w_imm;
    w_new.illegal = (bus.if_instr[1:0] != 2'b11);
  end

  assign w_accept = bus.if_valid & ~r_skid_valid;
  assign w_drain  = r_main_valid & bus.de_ready;

  // The skid slot only fills while main is stalled, and main always refills from skid first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid || w_drain) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main       <= w_new;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_new;
      r_skid_valid <= 1'b1;
    end
  end

  assign bus.if_ready   = ~r_skid_valid;
  assign bus.de_valid   = r_main_valid;
  assign bus.de_pc      = r_main.pc;
  assign bus.de_cs_addr = r_main.cs_addr;
  assign bus.de_rs1     = r_main.rs1;
  assign bus.de_rs2     = r_main.rs2;
  assign bus.de_rd      = r_main.rd;
  assign bus.de_imm     = r_main.imm;
  assign bus.de_illegal = r_main.illegal;

endmodule
